latch_bank_wr_arb: RTL and testbench

Write controller and round-robin arbiter for a shared bank of level-sensitive D latches, each with an active-low gate (transparent while its gate is low). Several requesters share one data bus into the bank. The block grants one requester at a time and drives the shared data. It opens exactly one latch gate using a setup / open / hold sequence, so data never changes while any gate is open. It sits between the requesting datapath logic and the latch bank.

---
 rtl/latch_ctrl_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/latch_bank_wr_arb.sv | 147 ++++++++++++++
 tb/tb_latch_bank_wr_arb.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/latch_ctrl_pkg.sv
// Shared types and helpers for the latch bank write controller.
// Holds the controller state encoding and the sequencing counter width rule.
package latch_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StOpen,
        StHold,
        StDone
    } state_e;

    // Counter loads (duration - 1), so it must hold the largest phase length.
    function automatic int cnt_width(input int setup, input int pulse, input int hold);
        int m;
        m = setup;
        if (pulse > m) m = pulse;
        if (hold > m) m = hold;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
// The pointer moves to the requester after the winner whenever advance is pulsed.
module rr_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] win
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr_q, ptr_d, win_idx;
    int unsigned   idx;

    // Scan from lowest to highest priority so the highest-priority match is written last.
    always_comb begin
        win     = '0;
        win_idx = '0;
        idx     = 0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            idx = (int'(ptr_q) + j) % NREQ;
            if (((req >> idx) & NREQ'(1)) != '0) begin
                win     = NREQ'(1) << idx;
                win_idx = PW'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/latch_bank_wr_arb.sv
// Write controller for a bank of active-low gated D latches shared by several requesters.
// Each write runs setup / open / hold so lat_d never moves while a gate is open.
module latch_bank_wr_arb
    import latch_ctrl_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = $clog2(DEPTH),
    parameter int unsigned SETUP = 1,
    parameter int unsigned PULSE = 1,
    parameter int unsigned HOLD  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*W-1:0] wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              err,
    output logic [W-1:0]      lat_d,
    output logic [DEPTH-1:0]  lat_g_n,
    output logic              busy
);

    localparam int unsigned CW = cnt_width(SETUP, PULSE, HOLD);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [W-1:0]      lat_d_q, lat_d_d;
    logic [DEPTH-1:0]  gate_q, gate_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic              err_q, err_d;
    logic [NREQ-1:0]   win;
    logic              advance;
    logic              addr_ok;
    logic [AW-1:0]     cap_addr;
    logic [W-1:0]      cap_data;

    assign advance = (state_q == StIdle) && (|req);
    assign addr_ok = 32'(addr_q) < DEPTH;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (advance),
        .win     (win)
    );

    always_comb begin
        cap_addr = '0;
        cap_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win[i]) begin
                cap_addr = addr[i*AW +: AW];
                cap_data = wdata[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            lat_d_q <= '0;
            gate_q  <= '1;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            lat_d_q <= lat_d_d;
            gate_q  <= gate_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Counter reloads with (phase length - 1) on every state change.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (|req) state_d = StSetup;
            StSetup: if (cnt_q == '0) state_d = StOpen;
            StOpen:  if (cnt_q == '0) state_d = StHold;
            StHold:  if (cnt_q == '0) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        cnt_d = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        if (state_d != state_q) begin
            unique case (state_d)
                StSetup: cnt_d = CW'(SETUP - 1);
                StOpen:  cnt_d = CW'(PULSE - 1);
                StHold:  cnt_d = CW'(HOLD - 1);
                default: cnt_d = '0;
            endcase
        end
    end

    // Output registers are loaded from the next state so every pin comes straight off a flop.
    always_comb begin
        addr_d  = addr_q;
        lat_d_d = lat_d_q;
        gnt_d   = gnt_q;
        gate_d  = '1;
        done_d  = '0;
        err_d   = 1'b0;

        if (advance) begin
            addr_d  = cap_addr;
            lat_d_d = cap_data;
            gnt_d   = win;
        end
        if (state_q == StDone) begin
            gnt_d = '0;
        end
        if (state_d == StOpen) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (32'(addr_q) == i) gate_d[i] = 1'b0;
            end
        end
        if (state_d == StDone) begin
            done_d = gnt_q;
            err_d  = !addr_ok;
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign err     = err_q;
    assign lat_d   = lat_d_q;
    assign lat_g_n = gate_q;
    assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_latch_bank_wr_arb.sv
// Bench for latch_bank_wr_arb: three instances (defaults, DEPTH=3, SETUP/PULSE/HOLD=2/3/2)
// checked every cycle against a transaction-offset model plus directed literal expectations.
module tb_latch_bank_wr_arb;

    localparam int SP[3] = '{1, 1, 2};
    localparam int PU[3] = '{1, 1, 3};
    localparam int HO[3] = '{1, 1, 2};
    localparam int DP[3] = '{4, 3, 4};

    logic       clk = 1'b0;
    logic       rst_a   [3];
    logic [3:0] req_a   [3];
    logic [7:0] addr_a  [3];
    logic [31:0] wdata_a[3];
    logic [3:0] gnt_a   [3];
    logic [3:0] done_a  [3];
    logic       err_a   [3];
    logic [7:0] latd_a  [3];
    logic       busy_a  [3];
    logic [3:0] gn0, gn2;
    logic [2:0] gn1;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    latch_bank_wr_arb #(.NREQ(4), .W(8), .DEPTH(4), .SETUP(1), .PULSE(1), .HOLD(1)) u0 (
        .clk(clk), .rst(rst_a[0]), .req(req_a[0]), .addr(addr_a[0]), .wdata(wdata_a[0]),
        .gnt(gnt_a[0]), .done(done_a[0]), .err(err_a[0]), .lat_d(latd_a[0]), .lat_g_n(gn0),
        .busy(busy_a[0])
    );

    latch_bank_wr_arb #(.NREQ(4), .W(8), .DEPTH(3), .SETUP(1), .PULSE(1), .HOLD(1)) u1 (
        .clk(clk), .rst(rst_a[1]), .req(req_a[1]), .addr(addr_a[1]), .wdata(wdata_a[1]),
        .gnt(gnt_a[1]), .done(done_a[1]), .err(err_a[1]), .lat_d(latd_a[1]), .lat_g_n(gn1),
        .busy(busy_a[1])
    );

    latch_bank_wr_arb #(.NREQ(4), .W(8), .DEPTH(4), .SETUP(2), .PULSE(3), .HOLD(2)) u2 (
        .clk(clk), .rst(rst_a[2]), .req(req_a[2]), .addr(addr_a[2]), .wdata(wdata_a[2]),
        .gnt(gnt_a[2]), .done(done_a[2]), .err(err_a[2]), .lat_d(latd_a[2]), .lat_g_n(gn2),
        .busy(busy_a[2])
    );

    function automatic logic [3:0] get_gn(input int i);
        if (i == 0) return gn0;
        if (i == 1) return {1'b1, gn1};
        return gn2;
    endfunction

    function automatic int tlen(input int i);
        return SP[i] + PU[i] + HO[i] + 1;
    endfunction

    function automatic int oh_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic chk(input string nm, input int inst, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s[u%0d] at %0t: got %0h, want %0h", nm, inst, $time, got, want);
        end
    endtask

    // Model: a transaction is (start edge t0, winner, addr, data); outputs follow from offset.
    int         cyc = 0;
    bit         act   [3];
    int         t0    [3];
    int         win   [3];
    int         maddr [3];
    logic [7:0] mdat  [3];
    int         ptr   [3];
    int         w;

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (!rst_a[i]) begin
                act[i]  = 0;
                ptr[i]  = 0;
                mdat[i] = 8'h00;
            end else if (act[i]) begin
                if (cyc - t0[i] == tlen(i)) act[i] = 0;
            end else if (req_a[i] != 4'h0) begin
                w = -1;
                for (int j = 0; j < 4; j++) begin
                    if (w < 0 && ((req_a[i] >> ((ptr[i] + j) % 4)) & 4'h1) != 4'h0)
                        w = (ptr[i] + j) % 4;
                end
                win[i]   = w;
                ptr[i]   = (w + 1) % 4;
                act[i]   = 1;
                t0[i]    = cyc;
                maddr[i] = int'((addr_a[i] >> (2 * w)) & 8'h03);
                mdat[i]  = 8'(wdata_a[i] >> (8 * w));
            end
        end
    end

    int         n;
    bit         last;
    logic [3:0] egnt, eg;

    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                n    = cyc - t0[i];
                last = act[i] && (n == tlen(i) - 1);
                egnt = act[i] ? (4'b0001 << win[i]) : 4'h0;
                eg   = 4'hF;
                if (act[i] && n >= SP[i] && n < SP[i] + PU[i] && maddr[i] < DP[i])
                    eg = eg & ~(4'b0001 << maddr[i]);
                chk("gnt", i, 32'(gnt_a[i]), 32'(egnt));
                chk("done", i, 32'(done_a[i]), last ? 32'(egnt) : 32'h0);
                chk("err", i, 32'(err_a[i]), 32'(last && maddr[i] >= DP[i]));
                chk("busy", i, 32'(busy_a[i]), 32'(act[i]));
                chk("lat_d", i, 32'(latd_a[i]), 32'(mdat[i]));
                chk("lat_g_n", i, 32'(get_gn(i)), 32'(eg));
            end
        end
    end

    int order[$];
    int cnt_g, cnt_low, cnt_done;
    logic [3:0] prev;

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_a[i]   = 1'b0;
            req_a[i]   = 4'h0;
            addr_a[i]  = 8'h00;
            wdata_a[i] = 32'h0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) rst_a[i] = 1'b1;
        chk_en = 1;
        chk("rst_gnt", 0, 32'(gnt_a[0]), 32'h0);
        chk("rst_gate", 0, 32'(gn0), 32'hF);
        chk("rst_lat_d", 0, 32'(latd_a[0]), 32'h0);
        chk("rst_busy", 0, 32'(busy_a[0]), 32'h0);

        // Single write: requester 2, addr 3, data A5.
        addr_a[0][5:4] = 2'd3;
        wdata_a[0][23:16] = 8'hA5;
        req_a[0] = 4'b0100;
        @(negedge clk);
        chk("sw_gnt", 0, 32'(gnt_a[0]), 32'h4);
        chk("sw_lat_d", 0, 32'(latd_a[0]), 32'hA5);
        chk("sw_setup_gate", 0, 32'(gn0), 32'hF);
        req_a[0] = 4'h0;
        @(negedge clk);
        chk("sw_open_gate", 0, 32'(gn0), 32'h7);
        @(negedge clk);
        chk("sw_hold_gate", 0, 32'(gn0), 32'hF);
        @(negedge clk);
        chk("sw_done", 0, 32'(done_a[0]), 32'h4);
        @(negedge clk);
        chk("sw_idle_gnt", 0, 32'(gnt_a[0]), 32'h0);

        // Requester 1 drops req and changes its data right after grant.
        addr_a[0][3:2] = 2'd1;
        wdata_a[0][15:8] = 8'h3C;
        req_a[0] = 4'b0010;
        @(negedge clk);
        chk("drop_gnt", 0, 32'(gnt_a[0]), 32'h2);
        req_a[0] = 4'h0;
        addr_a[0][3:2] = 2'd2;
        wdata_a[0][15:8] = 8'hFF;
        @(negedge clk);
        chk("drop_gate", 0, 32'(gn0), 32'hD);
        repeat (2) @(negedge clk);
        chk("drop_done", 0, 32'(done_a[0]), 32'h2);
        chk("drop_lat_d", 0, 32'(latd_a[0]), 32'h3C);
        @(negedge clk);

        // Reset while the gate of word 0 is open.
        addr_a[0][7:6] = 2'd0;
        wdata_a[0][31:24] = 8'h11;
        req_a[0] = 4'b1000;
        @(negedge clk);
        chk("mid_gnt", 0, 32'(gnt_a[0]), 32'h8);
        req_a[0] = 4'h0;
        @(negedge clk);
        chk("mid_open", 0, 32'(gn0), 32'hE);
        rst_a[0] = 1'b0;
        @(negedge clk);
        chk("mid_rst_gate", 0, 32'(gn0), 32'hF);
        chk("mid_rst_gnt", 0, 32'(gnt_a[0]), 32'h0);
        chk("mid_rst_lat_d", 0, 32'(latd_a[0]), 32'h0);
        chk("mid_rst_busy", 0, 32'(busy_a[0]), 32'h0);
        chk("mid_rst_done", 0, 32'(done_a[0]), 32'h0);

        // All four requesting for 40 cycles.
        rst_a[0]   = 1'b1;
        addr_a[0]  = 8'b11_10_01_00;
        wdata_a[0] = 32'h13121110;
        req_a[0]   = 4'hF;
        @(negedge clk);
        chk("rr_first", 0, 32'(gnt_a[0]), 32'h1);
        order.push_back(oh_idx(gnt_a[0]));
        for (int k = 1; k < 40; k++) begin
            prev = gnt_a[0];
            @(negedge clk);
            if (prev == 4'h0 && gnt_a[0] != 4'h0) order.push_back(oh_idx(gnt_a[0]));
        end
        req_a[0] = 4'h0;
        chk("rr_count", 0, 32'(order.size()), 32'd8);
        foreach (order[k]) chk("rr_order", 0, 32'(order[k]), 32'(k % 4));
        repeat (6) @(negedge clk);

        // DEPTH=3: address 3 is out of range.
        addr_a[1][1:0] = 2'd3;
        wdata_a[1][7:0] = 8'h5A;
        req_a[1] = 4'b0001;
        @(negedge clk);
        chk("oob_gnt", 1, 32'(gnt_a[1]), 32'h1);
        req_a[1] = 4'h0;
        cnt_low = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (gn1 != 3'b111) cnt_low++;
            if (k == 3) begin
                chk("oob_done", 1, 32'(done_a[1]), 32'h1);
                chk("oob_err", 1, 32'(err_a[1]), 32'h1);
            end
        end
        chk("oob_gate_low", 1, 32'(cnt_low), 32'd0);
        addr_a[1][3:2] = 2'd2;
        wdata_a[1][15:8] = 8'h6B;
        req_a[1] = 4'b0010;
        @(negedge clk);
        chk("inr_gnt", 1, 32'(gnt_a[1]), 32'h2);
        req_a[1] = 4'h0;
        @(negedge clk);
        chk("inr_gate", 1, 32'(gn1), 32'h3);
        repeat (2) @(negedge clk);
        chk("inr_done", 1, 32'(done_a[1]), 32'h2);
        chk("inr_err", 1, 32'(err_a[1]), 32'h0);
        @(negedge clk);

        // SETUP=2, PULSE=3, HOLD=2.
        addr_a[2][7:6] = 2'd1;
        wdata_a[2][31:24] = 8'hC3;
        req_a[2] = 4'b1000;
        cnt_g = 0;
        cnt_low = 0;
        cnt_done = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 0) req_a[2] = 4'h0;
            if (gnt_a[2] != 4'h0) cnt_g++;
            if (gn2 != 4'hF) cnt_low++;
            if (done_a[2] != 4'h0) cnt_done++;
        end
        chk("sweep_gnt_width", 2, 32'(cnt_g), 32'd8);
        chk("sweep_gate_width", 2, 32'(cnt_low), 32'd3);
        chk("sweep_done_count", 2, 32'(cnt_done), 32'd1);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
